// File: rtl/my_serial_adder.sv
// ---------------------------------------------------------------------------
// my_serial_adder
//
// Bit-serial adder for WIDTH-bit operands built around one my_full_adder cell.
// Operand bits are fed to the cell LSB first, one pair per clock. The returned
// carry is registered for the next bit, and the returned sum bits are
// collected in a shift register. A WIDTH-bit addition takes WIDTH cycles.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request to begin an addition (accepted only when idle)
//   a, b   - operands, captured on the accepted start edge
//   cin    - carry-in, captured on the accepted start edge
//   busy   - high while an addition is in progress (state RUN)
//   done   - one-cycle pulse marking a completed result
//   sum    - registered result of the last completed addition
//   cout   - registered carry-out of the last completed addition
//
// Handshake: start is a request that is accepted at a rising edge only when
// busy is low. It is ignored while busy is high. The result is valid on
// sum/cout in the cycle where done is high, and it holds until the next
// completion. start may be high in the done cycle, and it is then accepted
// at that edge (back-to-back operation).
// ---------------------------------------------------------------------------

// Single-bit full adder. Port order: (sum, carry, a, b, c).
module my_full_adder (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module my_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             last_bit;

  // Shift right by one with a new MSB. This form also works for WIDTH == 1,
  // where a slice such as v[WIDTH-1:1] would be reversed.
  function automatic logic [WIDTH-1:0] shr_in(input logic msb,
                                              input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r            = v >> 1;
    r[WIDTH-1]   = msb;
    return r;
  endfunction

  my_full_adder u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry_q)
  );

  assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy     = (state == RUN);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start)    state_d = RUN;
      RUN:  if (last_bit) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          s_sh    <= shr_in(fa_sum, s_sh);
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fa_carry;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            // The last sum bit bypasses s_sh so the result lands on this edge.
            sum  <= shr_in(fa_sum, s_sh);
            cout <= fa_carry;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_my_serial_adder.sv
`timescale 1ns/1ps
module tb_my_serial_adder;

  localparam int W = 8;
  localparam int MAX_WAIT = 20;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  my_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // ---------------- driver tasks ----------------
  // Present one start pulse and wait (bounded) for done. lat counts edges
  // from the start edge to the edge where done was first seen; busy_n counts
  // samples with busy high before done. All samples taken 1ns after posedge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, output int lat, output int busy_n,
                        output logic [W-1:0] s, output logic c);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_n = busy ? 1 : 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) busy_n++;
    end
    s = sum;
    c = cout;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 8'h5A ^ 8'(i * 37);
      b = 8'hC3 + 8'(i);
      cin = i[0];
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                 i, busy, done, sum, cout);
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bn;
    logic [W-1:0] s;
    logic c;
    run_op(8'h35, 8'h0A, 1'b0, lat, bn, s, c);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, want 8", lat);
    end
    checks++;
    if (bn != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", bn);
    end
    checks++;
    if (s !== 8'h3F || c !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h cout=%b busy=%b, want 3f 0 0", s, c, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || sum !== 8'h3F) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b sum=%h, want 0 3f", done, sum);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] av [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] bv [3] = '{8'h01, 8'hFF, 8'h00};
    logic         cv [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [3] = '{8'h00, 8'hFF, 8'h01};
    logic         ec [3] = '{1'b1, 1'b1, 1'b0};
    int lat, bn;
    logic [W-1:0] s;
    logic c;
    for (int k = 0; k < 3; k++) begin
      run_op(av[k], bv[k], cv[k], lat, bn, s, c);
      checks++;
      if (lat != 8 || s !== es[k] || c !== ec[k]) begin
        errors++;
        $display("FAIL carry_%0d: lat=%0d sum=%h cout=%b, want 8 %h %b",
                 k, lat, s, c, es[k], ec[k]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int done_cnt = 0;
    int first_done = -1;
    int late_busy = 0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      // Pulse start with new operands for the third RUN edge.
      if (e == 3) begin
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = e;
      end
      if (first_done >= 0 && busy) late_busy++;
    end
    start = 1'b0;
    checks++;
    if (done_cnt != 1 || first_done != 8) begin
      errors++;
      $display("FAIL ignore_done_count: dones=%0d at edge %0d, want 1 at 8",
               done_cnt, first_done);
    end
    checks++;
    if (sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: sum=%h cout=%b, want 46 0", sum, cout);
    end
    checks++;
    if (late_busy != 0) begin
      errors++;
      $display("FAIL ignore_no_restart: busy seen %0d times after done, want 0", late_busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    checks++;
    if (lat != 8 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d sum=%h cout=%b, want 8 00 1", lat, sum, cout);
    end
    // Second operands presented in the done cycle, start still high.
    a = 8'h01; b = 8'h02; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    checks++;
    if (lat != 8 || sum !== 8'h03 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d sum=%h cout=%b, want 8 03 0", lat, sum, cout);
    end
  endtask

  task automatic test_mid_reset();
    int stray_done = 0;
    int lat, bn;
    logic [W-1:0] s;
    logic c;
    // Put a non-zero result on the outputs first (03 from the previous test
    // has cout=0, so make one with cout=1 too).
    run_op(8'hF0, 8'hF0, 1'b1, lat, bn, s, c);
    checks++;
    if (s !== 8'hE1 || c !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: sum=%h cout=%b, want e1 1", s, c);
    end
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
               busy, done, sum, cout);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done) stray_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) stray_done++;
    end
    checks++;
    if (stray_done != 0) begin
      errors++;
      $display("FAIL midrst_no_done: %0d done/busy samples, want 0", stray_done);
    end
    run_op(8'h0F, 8'hF0, 1'b1, lat, bn, s, c);
    checks++;
    if (lat != 8 || s !== 8'h00 || c !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after: lat=%0d sum=%h cout=%b, want 8 00 1", lat, s, c);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_serial_adder.md
# my_serial_adder

Bit-serial adder for WIDTH-bit operands. It sits directly around `my_full_adder`: it feeds the full adder one operand bit pair per clock, LSB first, and registers the returned carry for the next bit. It collects the returned sum bits into a result register. The block trades latency (WIDTH cycles) for a single full-adder cell and is the sequential consumer of that cell in the datapath.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range is WIDTH >= 1.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request to begin an addition; sampled on the rising edge.
- `a` input WIDTH: operand A; captured only when start is accepted.
- `b` input WIDTH: operand B; captured only when start is accepted.
- `cin` input 1: carry-in; captured only when start is accepted.
- `busy` output 1: high while an addition is in progress.
- `done` output 1: one-cycle pulse that marks a completed result.
- `sum` output WIDTH: result of the last completed addition.
- `cout` output 1: carry-out of the last completed addition.

## Operation
- Internally, one `my_full_adder` instance is connected as (sum, carry, a, b, c) to:
  - `a_sh[0]` and `b_sh[0]` as the operand bits,
  - `carry_q` as the carry input.
- Internal state:
  - `a_sh` and `b_sh`: WIDTH-bit operand shift registers.
  - `s_sh`: WIDTH-bit sum shift register.
  - `carry_q`: 1-bit carry register.
  - `cnt`: bit counter, $clog2(WIDTH+1) bits wide.
  - FSM state: IDLE or RUN.
- IDLE behaviour:
  - With start=1 at an edge: load `a_sh`<=a, `b_sh`<=b, `carry_q`<=cin, `cnt`<=0; go to RUN.
  - With start=0: hold.
- RUN behaviour, at each edge:
  - `s_sh` <= {fa_sum, `s_sh`[WIDTH-1:1]}.
  - `a_sh` and `b_sh` shift right by one, with 0 filled in.
  - `carry_q` <= fa_carry.
  - `cnt` <= `cnt`+1.
- RUN exit: at the edge where `cnt`==WIDTH-1 (the last bit), also:
  - `sum` <= {fa_sum, `s_sh`[WIDTH-1:1]} and `cout` <= fa_carry;
  - `done` <= 1;
  - return to IDLE.
- Result semantics: {cout, sum} == a + b + cin, taken modulo 2^(WIDTH+1). Outputs come from the operands captured at start.
- `busy` is high exactly while the state is RUN.
- `sum` and `cout` are registered. They hold their value until the next completion and are not cleared at start.
- `start` is ignored while in RUN. Changes on a, b or cin during RUN have no effect.
- Back-to-back operation: start=1 while `done`=1 (state IDLE) is accepted at that edge.
- Reset (rst_n low, at any time, including mid-RUN):
  - Takes effect immediately, independent of `clk`.
  - state=IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - All internal registers cleared.
  - Any in-flight operation is aborted and produces no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Cycle-level sequence for start accepted at edge E0:
  - `busy` goes high after E0.
  - Bit i is processed at edge E0+1+i.
  - At edge E0+WIDTH: `sum`/`cout` update, `done` rises and `busy` falls.
  - `done` falls at edge E0+WIDTH+1, unless retriggered. `done` never stays high for two consecutive cycles.
- Latency from the start edge to valid `sum`/`cout` with `done`: WIDTH cycles.
- Throughput with start held high: one result per WIDTH+1 cycles.
- WIDTH=1 case:
  - RUN lasts a single edge;
  - `done` appears one cycle after the start edge.
- The full-adder path is combinational within a single cycle. There is no combinational path from the inputs to the outputs.

## Test plan
- Reset: hold rst_n=0 with start=1 and toggling operands -> `busy`=0, `done`=0, `sum`=8'h00, `cout`=0 throughout.
- Basic add (WIDTH=8): a=8'h35, b=8'h0A, cin=0, start for one cycle -> `busy` high for 8 cycles; `done` pulses exactly 8 edges after the start edge; `sum`=8'h3F, `cout`=0.
- Carry chain:
  - 8'hFF+8'h01, cin=0 -> `sum`=8'h00, `cout`=1.
  - 8'hFF+8'hFF, cin=1 -> `sum`=8'hFF, `cout`=1.
  - 8'h00+8'h00, cin=1 -> `sum`=8'h01, `cout`=0.
- Ignore while busy: start 8'h12+8'h34, then pulse start with a=8'hAA, b=8'h55 at RUN cycle 3 -> `sum`=8'h46, `cout`=0; only one `done`; no second operation begins.
- Back-to-back: start held high, first op 8'h80+8'h80, second op 8'h01+8'h02 presented on the `done` cycle -> first result `sum`=8'h00, `cout`=1; second start accepted on the `done` edge; second result `sum`=8'h03, `cout`=0 exactly 8 edges later.
- Mid-op reset: assert rst_n=0 asynchronously at RUN cycle 4 -> outputs go to 0 immediately and no `done` appears; after release, 8'h0F+8'hF0, cin=1 -> `sum`=8'h00, `cout`=1.
